// File: rtl/bcd4_scan_decoder.sv
// Receive-side decoder for a four-digit scanned BCD display bus: re-frames
// units/tens/hundreds/sign samples, converts to binary and commits after MATCH identical frames.
module bcd4_scan_decoder #(
    parameter int MATCH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] seg,
    input  logic [3:0] an,
    output logic [8:0] val,
    output logic       neg,
    output logic       valid,
    output logic       err
);

    localparam logic [2:0] MATCH_C = 3'(MATCH);

    typedef enum logic [2:0] {SLOT_U, SLOT_T, SLOT_H, SLOT_S, SLOT_BAD} slot_t;
    typedef enum logic [1:0] {WAIT_U, GOT_U, GOT_T, GOT_H} state_t;

    // Assertion propagates asynchronously; release is retimed through two flops.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_reg <= 2'b00;
        else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end

    assign rst_int_n = rst_sync_reg[1];

    slot_t slot;
    logic  digit_ok;

    always_comb begin
        slot     = SLOT_BAD;
        digit_ok = 1'b0;
        case (an)
            4'b1110: begin slot = SLOT_U; digit_ok = (seg <= 4'd9); end
            4'b1101: begin slot = SLOT_T; digit_ok = (seg <= 4'd9); end
            4'b1011: begin slot = SLOT_H; digit_ok = (seg <= 4'd5); end
            4'b0111: begin slot = SLOT_S; digit_ok = (seg == 4'hF); end
            default: begin slot = SLOT_BAD; digit_ok = 1'b0; end
        endcase
    end

    state_t     state_reg, state_next;
    logic [3:0] u_reg, u_next;
    logic [3:0] t_reg, t_next;
    logic [3:0] h_reg, h_next;
    logic       snap, snap_neg, frame_err;

    always_comb begin
        state_next = state_reg;
        u_next     = u_reg;
        t_next     = t_reg;
        h_next     = h_reg;
        snap       = 1'b0;
        snap_neg   = 1'b0;
        frame_err  = 1'b0;
        if (tick) begin
            case (state_reg)
                WAIT_U: begin
                    // Start-up sync: only a bad units digit is worth flagging here.
                    if (slot == SLOT_U) begin
                        if (digit_ok) begin
                            u_next     = seg;
                            state_next = GOT_U;
                        end else begin
                            frame_err = 1'b1;
                        end
                    end
                end
                GOT_U: begin
                    if (slot == SLOT_T && digit_ok) begin
                        t_next     = seg;
                        state_next = GOT_T;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                GOT_T: begin
                    if (slot == SLOT_H && digit_ok) begin
                        h_next     = seg;
                        state_next = GOT_H;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                GOT_H: begin
                    if (slot == SLOT_U && digit_ok) begin
                        snap       = 1'b1;
                        u_next     = seg;
                        state_next = GOT_U;
                    end else if (slot == SLOT_S && digit_ok) begin
                        snap       = 1'b1;
                        snap_neg   = 1'b1;
                        state_next = WAIT_U;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_next = WAIT_U;
            endcase
            if (frame_err) begin
                if (slot == SLOT_U && digit_ok) begin
                    u_next     = seg;
                    state_next = GOT_U;
                end else begin
                    state_next = WAIT_U;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_reg <= WAIT_U;
            u_reg     <= 4'd0;
            t_reg     <= 4'd0;
            h_reg     <= 4'd0;
        end else begin
            state_reg <= state_next;
            u_reg     <= u_next;
            t_reg     <= t_next;
            h_reg     <= h_next;
        end
    end

    // Converter: step 1..3 are C1..C3; a snapshot is only accepted while idle.
    logic [1:0] cnv_step_reg;
    logic [3:0] snap_h_reg, snap_t_reg, snap_u_reg;
    logic       snap_neg_reg;
    logic [9:0] acc_reg;
    logic [9:0] h_ext, t_ext, acc_final;
    logic       busy, snap_take, snap_drop, cnv_done;

    assign busy      = (cnv_step_reg != 2'd0);
    assign snap_take = snap && !busy;
    assign snap_drop = snap && busy;
    assign cnv_done  = (cnv_step_reg == 2'd3);
    assign h_ext     = {6'd0, snap_h_reg};
    assign t_ext     = {6'd0, snap_t_reg};
    assign acc_final = acc_reg + {6'd0, snap_u_reg};

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnv_step_reg <= 2'd0;
            snap_h_reg   <= 4'd0;
            snap_t_reg   <= 4'd0;
            snap_u_reg   <= 4'd0;
            snap_neg_reg <= 1'b0;
            acc_reg      <= 10'd0;
        end else if (snap_take) begin
            cnv_step_reg <= 2'd1;
            snap_h_reg   <= h_reg;
            snap_t_reg   <= t_reg;
            snap_u_reg   <= u_reg;
            snap_neg_reg <= snap_neg;
        end else begin
            case (cnv_step_reg)
                2'd1: begin
                    acc_reg      <= (h_ext << 6) + (h_ext << 5) + (h_ext << 2);
                    cnv_step_reg <= 2'd2;
                end
                2'd2: begin
                    acc_reg      <= acc_reg + (t_ext << 3) + (t_ext << 1);
                    cnv_step_reg <= 2'd3;
                end
                2'd3:    cnv_step_reg <= 2'd0;
                default: cnv_step_reg <= 2'd0;
            endcase
        end
    end

    // Match filter over {magnitude, sign}.
    logic [2:0] cnt_reg, cnt_next;
    logic [9:0] cand_reg, cand_next;
    logic [9:0] result;
    logic       overflow, commit, ovf_err;

    assign result   = {acc_final[8:0], snap_neg_reg};
    assign overflow = acc_final[9];

    always_comb begin
        cnt_next  = cnt_reg;
        cand_next = cand_reg;
        commit    = 1'b0;
        ovf_err   = 1'b0;
        if (cnv_done) begin
            if (overflow) begin
                ovf_err  = 1'b1;
                cnt_next = 3'd0;
            end else begin
                if (result == cand_reg) begin
                    cnt_next = (cnt_reg >= MATCH_C) ? MATCH_C : cnt_reg + 3'd1;
                end else begin
                    cand_next = result;
                    cnt_next  = 3'd1;
                end
                commit = (cnt_next == MATCH_C);
            end
        end
        if (frame_err || snap_drop) cnt_next = 3'd0;
    end

    logic [8:0] val_reg;
    logic       neg_reg, valid_reg, err_reg;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt_reg   <= 3'd0;
            cand_reg  <= 10'd0;
            val_reg   <= 9'd0;
            neg_reg   <= 1'b0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            valid_reg <= commit;
            err_reg   <= frame_err | snap_drop | ovf_err;
            if (commit) begin
                val_reg <= result[9:1];
                neg_reg <= result[0];
            end
        end
    end

    assign val   = val_reg;
    assign neg   = neg_reg;
    assign valid = valid_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_bcd4_scan_decoder.sv
// Bench for bcd4_scan_decoder: directed scenarios plus randomized frame streams,
// checked cycle by cycle against a digit-queue/arithmetic reference model.
module tb_bcd4_scan_decoder;

    localparam int MATCH = 2;
    localparam logic [3:0] AN_U = 4'b1110;
    localparam logic [3:0] AN_T = 4'b1101;
    localparam logic [3:0] AN_H = 4'b1011;
    localparam logic [3:0] AN_S = 4'b0111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] seg = 4'd0;
    logic [3:0] an = 4'b1111;
    logic [8:0] val;
    logic       neg, valid, err;

    bcd4_scan_decoder #(.MATCH(MATCH)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .seg(seg), .an(an),
        .val(val), .neg(neg), .valid(valid), .err(err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model: accepted digits of the frame in progress (u first), pending conversion.
    int fq[$];
    int pend, p_val, cand_v, mcnt, m_val;
    bit p_neg, cand_n, m_neg, m_valid, m_err;
    int m_valid_total, m_err_total;
    int n_valid, n_err, cyc_bad;

    function automatic void model_reset();
        fq.delete();
        pend = 0; p_val = 0; p_neg = 0;
        cand_v = 0; cand_n = 0; mcnt = 0;
        m_val = 0; m_neg = 0; m_valid = 0; m_err = 0;
    endfunction

    function automatic void model_edge(bit t, logic [3:0] a, logic [3:0] s);
        int old, slot, v;
        bit ok, bad;
        old = pend;
        bad = 0;
        m_valid = 0;
        m_err = 0;
        if (old > 0) begin
            pend--;
            if (pend == 0) begin
                if (p_val > 511) begin
                    m_err = 1; mcnt = 0;
                end else begin
                    if (p_val == cand_v && p_neg == cand_n) mcnt = (mcnt < MATCH) ? mcnt + 1 : MATCH;
                    else begin cand_v = p_val; cand_n = p_neg; mcnt = 1; end
                    if (mcnt == MATCH) begin
                        m_val = p_val; m_neg = p_neg; m_valid = 1; m_valid_total++;
                    end
                end
            end
        end
        if (t) begin
            case (a)
                AN_U: begin slot = 0; ok = (s <= 9); end
                AN_T: begin slot = 1; ok = (s <= 9); end
                AN_H: begin slot = 2; ok = (s <= 5); end
                AN_S: begin slot = 3; ok = (s == 15); end
                default: begin slot = -1; ok = 0; end
            endcase
            if (fq.size() == 0) begin
                if (slot == 0) begin
                    if (ok) fq.push_back(int'(s));
                    else bad = 1;
                end
            end else if (fq.size() < 3 && slot == fq.size() && ok) begin
                fq.push_back(int'(s));
            end else if (fq.size() == 3 && ok && (slot == 0 || slot == 3)) begin
                v = fq[2] * 100 + fq[1] * 10 + fq[0];
                fq.delete();
                if (slot == 0) fq.push_back(int'(s));
                if (old > 0) bad = 1;
                else begin pend = 3; p_val = v; p_neg = (slot == 3); end
            end else begin
                bad = 1;
                fq.delete();
                if (slot == 0 && ok) fq.push_back(int'(s));
            end
            if (bad) begin m_err = 1; mcnt = 0; end
        end
        if (m_err) m_err_total++;
    endfunction

    task automatic step(input logic t, input logic [3:0] a, input logic [3:0] s);
        tick = t; an = a; seg = s;
        @(posedge clk);
        model_edge(t, a, s);
        #1;
        tick = 1'b0;
        if (valid === 1'b1) n_valid++;
        if (err === 1'b1) n_err++;
        if ({valid, err, val, neg} !== {m_valid, m_err, 9'(m_val), m_neg}) begin
            if (cyc_bad < 10)
                $display("t=%0t output differs: valid=%b err=%b val=%0d neg=%b model valid=%b err=%b val=%0d neg=%b",
                         $time, valid, err, val, neg, m_valid, m_err, m_val, m_neg);
            cyc_bad++;
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] s, input int gap);
        step(1'b1, a, s);
        repeat (gap - 1) step(1'b0, a, s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        n_valid = 0; n_err = 0; cyc_bad = 0;
    endtask

    task automatic test_reset();
        start_test();
        #3 rst_n = 1'b0;
        #1;
        compared++;
        if ({val, neg, valid, err} !== 12'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got val=%0d neg=%b valid=%b err=%b, required all 0", val, neg, valid, err);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        repeat (6) step(1'b0, 4'b1111, 4'd0);
        compared++;
        if (n_valid + n_err !== 0) begin
            mismatched++;
            $display("FAIL reset_idle_pulses: got %0d pulses, required 0", n_valid + n_err);
        end
    endtask

    task automatic test_positive();
        do_reset();
        start_test();
        repeat (3) begin
            send(AN_U, 4'd7, 8); send(AN_T, 4'd3, 8); send(AN_H, 4'd2, 8);
        end
        send(AN_U, 4'd7, 8);
        compared++;
        if (cyc_bad !== 0) begin mismatched++; $display("FAIL pos_lockstep: got %0d differing cycles, required 0", cyc_bad); end
        compared++;
        if (n_valid !== 2) begin mismatched++; $display("FAIL pos_valid_count: got %0d, required 2", n_valid); end
        compared++;
        if (val !== 9'd237 || neg !== 1'b0) begin mismatched++; $display("FAIL pos_value: got %0d/%b, required 237/0", val, neg); end
    endtask

    task automatic test_negative();
        do_reset();
        start_test();
        repeat (3) begin
            send(AN_U, 4'd5, 8); send(AN_T, 4'd4, 8); send(AN_H, 4'd0, 8); send(AN_S, 4'hF, 8);
        end
        compared++;
        if (cyc_bad !== 0) begin mismatched++; $display("FAIL neg_lockstep: got %0d differing cycles, required 0", cyc_bad); end
        compared++;
        if (n_valid !== 2 || n_err !== 0) begin mismatched++; $display("FAIL neg_pulses: got valid=%0d err=%0d, required 2/0", n_valid, n_err); end
        compared++;
        if (val !== 9'd45 || neg !== 1'b1) begin mismatched++; $display("FAIL neg_value: got %0d/%b, required 45/1", val, neg); end
    endtask

    task automatic test_framing();
        do_reset();
        start_test();
        send(AN_U, 4'd1, 8); send(AN_H, 4'd3, 8);
        send(AN_U, 4'd1, 8); send(AN_T, 4'd2, 8); send(4'b1111, 4'd0, 8);
        send(AN_U, 4'd1, 8); send(4'b1001, 4'd2, 8);
        send(AN_U, 4'd1, 8); send(AN_T, 4'd2, 8); send(AN_H, 4'd3, 8); send(AN_U, 4'd1, 8);
        compared++;
        if (cyc_bad !== 0) begin mismatched++; $display("FAIL frame_lockstep: got %0d differing cycles, required 0", cyc_bad); end
        compared++;
        if (n_err !== 3 || n_valid !== 0) begin mismatched++; $display("FAIL frame_pulses: got err=%0d valid=%0d, required 3/0", n_err, n_valid); end
    endtask

    task automatic test_bad_digit();
        do_reset();
        start_test();
        repeat (2) begin send(AN_U, 4'd3, 8); send(AN_T, 4'd2, 8); send(AN_H, 4'd1, 8); end
        send(AN_U, 4'd3, 8);
        send(AN_T, 4'hA, 8);
        send(AN_H, 4'd1, 8);
        repeat (2) begin send(AN_U, 4'd3, 8); send(AN_T, 4'd2, 8); send(AN_H, 4'd1, 8); end
        send(AN_U, 4'd3, 8);
        compared++;
        if (cyc_bad !== 0) begin mismatched++; $display("FAIL digit_lockstep: got %0d differing cycles, required 0", cyc_bad); end
        compared++;
        if (n_err !== 1 || n_valid !== 2) begin mismatched++; $display("FAIL digit_pulses: got err=%0d valid=%0d, required 1/2", n_err, n_valid); end
        compared++;
        if (val !== 9'd123 || neg !== 1'b0) begin mismatched++; $display("FAIL digit_value: got %0d/%b, required 123/0", val, neg); end
    endtask

    task automatic test_overflow();
        start_test();
        send(AN_U, 4'd9, 8);
        repeat (3) begin send(AN_T, 4'd9, 8); send(AN_H, 4'd5, 8); send(AN_U, 4'd9, 8); end
        compared++;
        if (cyc_bad !== 0) begin mismatched++; $display("FAIL ovf_lockstep: got %0d differing cycles, required 0", cyc_bad); end
        compared++;
        if (n_err !== 4 || n_valid !== 0) begin mismatched++; $display("FAIL ovf_pulses: got err=%0d valid=%0d, required 4/0", n_err, n_valid); end
        compared++;
        if (val !== 9'd123) begin mismatched++; $display("FAIL ovf_hold_value: got %0d, required 123", val); end
    endtask

    task automatic test_reset_mid_conversion();
        do_reset();
        start_test();
        repeat (2) begin send(AN_U, 4'd7, 8); send(AN_T, 4'd3, 8); send(AN_H, 4'd2, 8); end
        step(1'b1, AN_U, 4'd7);
        step(1'b0, AN_U, 4'd7);
        step(1'b0, AN_U, 4'd7);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) n_valid++;
        end
        compared++;
        if (n_valid !== 0 || val !== 9'd0) begin mismatched++; $display("FAIL midrst_abort: got valid=%0d val=%0d, required 0/0", n_valid, val); end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_test();
        repeat (2) begin send(AN_U, 4'd7, 8); send(AN_T, 4'd3, 8); send(AN_H, 4'd2, 8); end
        send(AN_U, 4'd7, 8);
        compared++;
        if (cyc_bad !== 0 || n_valid !== 1 || val !== 9'd237) begin
            mismatched++;
            $display("FAIL midrst_recommit: got bad=%0d valid=%0d val=%0d, required 0/1/237", cyc_bad, n_valid, val);
        end
    endtask

    task automatic test_random();
        int v, reps, vt0, et0;
        bit ng;
        logic [3:0] a, s;
        logic [3:0] fa[4];
        logic [3:0] fs[4];
        do_reset();
        start_test();
        vt0 = m_valid_total; et0 = m_err_total;
        for (int i = 0; i < 60; i++) begin
            v = $urandom_range(0, 599);
            ng = 1'($urandom_range(0, 1));
            reps = $urandom_range(1, 3);
            fa[0] = AN_U; fs[0] = 4'(v % 10);
            fa[1] = AN_T; fs[1] = 4'((v / 10) % 10);
            fa[2] = AN_H; fs[2] = 4'(v / 100);
            fa[3] = AN_S; fs[3] = 4'hF;
            repeat (reps) begin
                for (int k = 0; k < (ng ? 4 : 3); k++) begin
                    a = fa[k]; s = fs[k];
                    if ($urandom_range(0, 24) == 0) begin
                        a = 4'($urandom); s = 4'($urandom);
                    end
                    send(a, s, $urandom_range(4, 7));
                end
            end
        end
        repeat (6) step(1'b0, 4'b1111, 4'd0);
        compared++;
        if (cyc_bad !== 0) begin mismatched++; $display("FAIL rand_lockstep: got %0d differing cycles, required 0", cyc_bad); end
        compared++;
        if (n_valid !== m_valid_total - vt0) begin mismatched++; $display("FAIL rand_valid_count: got %0d, required %0d", n_valid, m_valid_total - vt0); end
        compared++;
        if (n_err !== m_err_total - et0) begin mismatched++; $display("FAIL rand_err_count: got %0d, required %0d", n_err, m_err_total - et0); end
    endtask

    initial begin
        m_valid_total = 0;
        m_err_total = 0;
        model_reset();
        test_reset();
        test_positive();
        test_negative();
        test_framing();
        test_bad_digit();
        test_overflow();
        test_reset_mid_conversion();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
